// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master and its clock generator.
package spi_pkg;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned FRAME_BITS = 9;
  localparam int unsigned BIT_IDX_W  = 4;
  localparam int unsigned BIT_SEL_W  = 3;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD,
    GAP
  } spi_state_e;

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period tick generator: counts 0..CLK_DIV-1 and flags the last count.
module spi_clk_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic i_reset_n,
  input  logic i_clr,
  output logic o_tick_c
);

  localparam int unsigned CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] cnt_q;

  assign o_tick_c = (cnt_q == CNT_W'(CLK_DIV - 1));

  // Free-running half-period counter, wraps on tick, held at zero by clear.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt_q <= '0;
    end else if (i_clr || o_tick_c) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/spi_master.sv
// Single-CS SPI master producing a 9-bit frame: R/W flag then 8 data bits LSB first.
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              i_reset_n,
  input  logic              i_start,
  input  logic              i_rw,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_rdata,
  output logic              sclk,
  output logic              cs,
  output logic              mosi,
  input  logic              miso
);

  spi_state_e           state_q;
  logic                 rw_q;
  logic [DATA_W-1:0]    wdata_q;
  logic [DATA_W-1:0]    sh_q;
  logic [DATA_W-1:0]    rdata_q;
  logic [BIT_IDX_W-1:0] bit_idx_q;
  logic                 sclk_q;
  logic                 cs_q;
  logic                 mosi_q;
  logic                 busy_q;
  logic                 done_q;

  logic                 tick_c;
  logic                 clr_c;

  // Counter is parked at zero in IDLE so SETUP always starts a full half-period;
  // every other state entry happens on a tick, which wraps the counter anyway.
  assign clr_c = (state_q == IDLE);

  spi_clk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_gen (
    .clk      (clk),
    .i_reset_n(i_reset_n),
    .i_clr    (clr_c),
    .o_tick_c (tick_c)
  );

  // Frame sequencer: drives the SPI pins, shifts data and reports completion.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= IDLE;
      rw_q      <= RW_WRITE;
      wdata_q   <= '0;
      sh_q      <= '0;
      rdata_q   <= '0;
      bit_idx_q <= '0;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b1;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_start) begin
            rw_q    <= i_rw;
            wdata_q <= i_wdata;
            cs_q    <= 1'b0;
            mosi_q  <= i_rw;
            busy_q  <= 1'b1;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          if (tick_c) begin
            sclk_q    <= 1'b1;
            bit_idx_q <= '0;
            state_q   <= XFER;
          end
        end
        XFER: begin
          if (tick_c) begin
            if (!sclk_q) begin
              sclk_q <= 1'b1;
            end else begin
              sclk_q <= 1'b0;
              // Falling edge k>=1 captures the bit the slave launched on rising edge k.
              if ((bit_idx_q != '0) && (rw_q == RW_READ)) begin
                sh_q <= {miso, sh_q[DATA_W-1:1]};
              end
              if (bit_idx_q == BIT_IDX_W'(FRAME_BITS - 1)) begin
                mosi_q  <= 1'b0;
                state_q <= HOLD;
              end else begin
                mosi_q    <= (rw_q == RW_WRITE) ? wdata_q[bit_idx_q[BIT_SEL_W-1:0]] : 1'b0;
                bit_idx_q <= bit_idx_q + BIT_IDX_W'(1);
              end
            end
          end
        end
        HOLD: begin
          if (tick_c) begin
            cs_q    <= 1'b1;
            done_q  <= 1'b1;
            if (rw_q == RW_READ) begin
              rdata_q <= sh_q;
            end
            state_q <= GAP;
          end
        end
        GAP: begin
          if (tick_c) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_busy  = busy_q;
  assign o_done  = done_q;
  assign o_rdata = rdata_q;
  assign sclk    = sclk_q;
  assign cs      = cs_q;
  assign mosi    = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master with a behavioural SPI slave on the pins.
module tb_spi_master;

  localparam int unsigned CD  = 4;
  localparam int unsigned CD2 = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, rw;
  logic [7:0] wdata;
  logic       busy, done, sclk, cs, mosi, miso;
  logic [7:0] rdata;

  logic       start2, rw2;
  logic [7:0] wdata2;
  logic       busy2, done2, sclk2, cs2, mosi2;
  logic [7:0] rdata2;

  always #5 clk = ~clk;

  spi_master #(.CLK_DIV(CD)) dut (
    .clk(clk), .i_reset_n(rst_n), .i_start(start), .i_rw(rw), .i_wdata(wdata),
    .o_busy(busy), .o_done(done), .o_rdata(rdata),
    .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso)
  );

  spi_master #(.CLK_DIV(CD2)) dut2 (
    .clk(clk), .i_reset_n(rst_n), .i_start(start2), .i_rw(rw2), .i_wdata(wdata2),
    .o_busy(busy2), .o_done(done2), .o_rdata(rdata2),
    .sclk(sclk2), .cs(cs2), .mosi(mosi2), .miso(1'b0)
  );

  // Behavioural slave: frame counter realigned only by reset.
  logic [3:0] s_cnt;
  logic       s_rw;
  logic [7:0] s_wsh, s_dout;
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      s_cnt <= '0; s_rw <= 1'b0; s_wsh <= '0; s_dout <= '0; miso <= 1'b0;
    end else if (!cs) begin
      if (s_cnt == 4'd0) begin
        s_rw  <= mosi;
        s_cnt <= 4'd1;
      end else begin
        if (s_rw) miso <= s_dout[3'(s_cnt - 4'd1)];
        else begin
          s_wsh <= {mosi, s_wsh[7:1]};
          if (s_cnt == 4'd8) s_dout <= {mosi, s_wsh[7:1]};
        end
        s_cnt <= (s_cnt == 4'd8) ? 4'd0 : s_cnt + 4'd1;
      end
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic [7:0] rdata;
    logic [8:0] bits;
    logic [7:0] dout;
  } exp_t;
  exp_t sbq[$];

  task automatic push(input logic [7:0] r, input logic [8:0] b, input logic [7:0] d);
    exp_t e;
    e.rdata = r; e.bits = b; e.dout = d;
    sbq.push_back(e);
  endtask

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor for the CLK_DIV=4 instance: frame shape, timing and scoreboard pops.
  int         rcnt = 0;
  initial begin
    logic       cs_p, sclk_p, busy_p;
    logic [8:0] bits;
    int         t_cs, t_rise_cs;
    bit         have_rise, active;
    exp_t       e;
    cs_p = 1'b1; sclk_p = 1'b0; busy_p = 1'b0; bits = '0;
    t_cs = 0; t_rise_cs = 0; have_rise = 0; active = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        active = 0; rcnt = 0; have_rise = 0;
      end else begin
        if (cs_p && !cs) begin
          if (have_rise) chk("cs_gap_ge_div", 32'(cyc - t_rise_cs >= int'(CD)), 1);
          t_cs = cyc; rcnt = 0; bits = '0; active = 1;
        end
        if (!cs_p && cs) begin
          t_rise_cs = cyc; have_rise = 1;
        end
        if (sclk && !sclk_p) begin
          if (rcnt < 9) bits[rcnt] = mosi;
          rcnt++;
        end
        if (done) begin
          if (sbq.size() == 0) chk("spurious_done", 32'(done), 0);
          else begin
            e = sbq.pop_front();
            chk("rdata", 32'(rdata), 32'(e.rdata));
            chk("mosi_bits", 32'(bits), 32'(e.bits));
            chk("sclk_rises", 32'(rcnt), 9);
            chk("done_latency", 32'(cyc - t_cs), 32'(19 * CD));
            chk("slave_dout", 32'(s_dout), 32'(e.dout));
          end
        end
        if (busy_p && !busy && active) begin
          chk("busy_latency", 32'(cyc - t_cs), 32'(20 * CD));
          active = 0;
        end
      end
      cs_p = cs; sclk_p = sclk; busy_p = busy;
    end
  end

  // Monitor for the CLK_DIV=2 instance: rising-edge bits and sclk period.
  int         rc2 = 0;
  int         per_min = 1000, per_max = 0;
  int         n_done2 = 0;
  logic [8:0] bits2 = '0;
  initial begin
    logic sclk2_p;
    int   t_last;
    sclk2_p = 1'b0; t_last = -1;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (sclk2 && !sclk2_p) begin
          if (rc2 < 9) bits2[rc2] = mosi2;
          rc2++;
          if (t_last >= 0) begin
            if (cyc - t_last < per_min) per_min = cyc - t_last;
            if (cyc - t_last > per_max) per_max = cyc - t_last;
          end
          t_last = cyc;
        end
        if (done2) n_done2++;
      end
      sclk2_p = sclk2;
    end
  end

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(busy), 0);
  endtask

  task automatic issue(input logic r, input logic [7:0] d);
    rw = r; wdata = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int n;
    int t2;
    rst_n = 1'b0; start = 1'b0; rw = 1'b0; wdata = '0;
    start2 = 1'b0; rw2 = 1'b0; wdata2 = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_cs", 32'(cs), 1);
    chk("rst_sclk", 32'(sclk), 0);
    chk("rst_mosi", 32'(mosi), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_rdata", 32'(rdata), 0);

    // Write 0xA5: rising-edge mosi 0,1,0,1,0,0,1,0,1.
    push(8'h00, 9'h14A, 8'hA5);
    issue(1'b0, 8'hA5);
    wait_idle("idle_a5");

    // Write 0x3C with a stray start while busy, plus input changes after accept.
    push(8'h00, 9'h078, 8'h3C);
    issue(1'b0, 8'h3C);
    repeat (9) @(negedge clk);
    rw = 1'b1; wdata = 8'h77; start = 1'b1;
    @(negedge clk);
    start = 1'b0; wdata = 8'h00;
    wait_idle("idle_ignore");

    // Read back the preloaded 0x3C.
    push(8'h3C, 9'h001, 8'h3C);
    issue(1'b1, 8'h00);
    wait_idle("idle_read");

    // Back-to-back writes with start held high.
    push(8'h3C, 9'h002, 8'h01);
    push(8'h3C, 9'h1FE, 8'hFF);
    rw = 1'b0; wdata = 8'h01; start = 1'b1;
    @(negedge clk);
    wdata = 8'hFF;
    n = 0;
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("b2b_restart", 32'(busy), 1);
    start = 1'b0;
    wait_idle("idle_b2b");

    // Abort a frame with reset after the 4th rising sclk edge.
    issue(1'b0, 8'h96);
    n = 0;
    while (rcnt < 4 && n < 400) begin
      @(posedge clk);
      n++;
    end
    chk("rises_before_rst", 32'(rcnt), 4);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_cs", 32'(cs), 1);
    chk("abort_sclk", 32'(sclk), 0);
    chk("abort_mosi", 32'(mosi), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_rdata", 32'(rdata), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);

    push(8'h00, 9'h0B4, 8'h5A);
    issue(1'b0, 8'h5A);
    wait_idle("idle_5a");
    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sbq.size()), 0);

    // CLK_DIV=2 instance: write 0x80.
    wdata2 = 8'h80; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    t2 = cyc;
    n = 0;
    while (busy2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("div2_frame_time", 32'(cyc - t2), 40);
    chk("div2_rises", 32'(rc2), 9);
    chk("div2_bits", 32'(bits2), 32'h100);
    chk("div2_last_bit", 32'(bits2[8]), 1);
    chk("div2_period_min", 32'(per_min), 4);
    chk("div2_period_max", 32'(per_max), 4);
    chk("div2_done_count", 32'(n_done2), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

endmodule
